// File: rtl/adder_settle_monitor.sv
// rtl/adder_settle_monitor.sv - settle-window glitch counter and golden-sum checker for a 4-bit adder
module adder_settle_monitor #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [WIDTH-1:0] sum,
  input  logic             co,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             res_err,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;

  localparam int              WC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         state;
  logic [2*WIDTH:0]   op_q;
  logic [WIDTH:0]     out_q;
  logic [WC_W-1:0]    win_cnt;
  logic [CNT_W-1:0]   acc;
  logic               op_chg;
  logic               out_chg;
  logic [WIDTH:0]     golden;
  logic               mismatch;

  assign op_chg  = ({a, b, ci} != op_q);
  assign out_chg = ({co, sum} != out_q);
  assign busy    = (state != S_IDLE);

  // Golden compare uses the registered operands so it lines up with out_q.
  assign golden   = {1'b0, op_q[2*WIDTH:WIDTH+1]} + {1'b0, op_q[WIDTH:1]}
                  + {{WIDTH{1'b0}}, op_q[0]};
  assign mismatch = (out_q != golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      out_q      <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_co     <= 1'b0;
      res_err    <= 1'b0;
      glitch_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      op_q      <= {a, b, ci};
      out_q     <= {co, sum};
      res_valid <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_chg) begin
              state   <= S_SETTLE;
              win_cnt <= '0;
              acc     <= '0;
            end
          end
          S_SETTLE: begin
            if (op_chg) begin
              win_cnt <= '0;
              acc     <= '0;
            end else begin
              if (out_chg && (acc != CNT_MAX))
                acc <= acc + CNT_W'(1);
              if (win_cnt == WC_LAST)
                state <= S_CHECK;
              else
                win_cnt <= win_cnt + WC_W'(1);
            end
          end
          S_CHECK: begin
            if (op_chg) begin
              state   <= S_SETTLE;
              win_cnt <= '0;
              acc     <= '0;
            end else begin
              state      <= S_IDLE;
              res_valid  <= 1'b1;
              res_sum    <= out_q[WIDTH-1:0];
              res_co     <= out_q[WIDTH];
              res_err    <= mismatch;
              glitch_cnt <= acc;
              if (mismatch && (err_cnt != CNT_MAX))
                err_cnt <= err_cnt + CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
